// File: rtl/mem_access_unit.sv
// Load/store unit between the EX/MEM stage and a single-beat word bus (IDLE/BUSY/DONE).
// Optional build macro MEM_MISALIGN_TRAP_EN traps misaligned half/word accesses without touching the bus.
module mem_access_unit #(
  parameter int BITS_SIZE = 32,
  parameter int TIMEOUT   = 16
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_step,
  input  logic                 i_mem_read,
  input  logic                 i_mem_write,
  input  logic [1:0]           i_datamem_size,
  input  logic                 i_zero_extend,
  input  logic [BITS_SIZE-1:0] i_alu,
  input  logic [BITS_SIZE-1:0] i_register_2,
  output logic                 o_bus_req,
  output logic                 o_bus_we,
  output logic [BITS_SIZE-1:0] o_bus_addr,
  output logic [3:0]           o_bus_be,
  output logic [BITS_SIZE-1:0] o_bus_wdata,
  input  logic                 i_bus_ack,
  input  logic [BITS_SIZE-1:0] i_bus_rdata,
  output logic                 o_stall,
  output logic [BITS_SIZE-1:0] o_load_data,
  output logic                 o_load_valid,
  output logic                 o_bus_error,
  output logic                 o_misaligned
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  state_t                 state, state_nxt;
  logic                   access, misalign, timeout_hit;
  logic [7:0]             wait_cnt;
  logic [BITS_SIZE-1:0]   addr_p0, wdata_p0;
  logic [3:0]             be_p0;
  logic                   we_p0, zext_p0;
  logic [1:0]             size_p0, lane_p0;
  logic [BITS_SIZE-1:0]   load_data_p1;
  logic                   vld_p1, err_p1;

  function automatic logic [3:0] byte_enable(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      2'b00:   byte_enable = 4'b0001 << lane;
      2'b01:   byte_enable = lane[1] ? 4'b1100 : 4'b0011;
      default: byte_enable = 4'b1111;
    endcase
  endfunction

  function automatic logic [BITS_SIZE-1:0] store_data(input logic [1:0] size,
                                                      input logic [BITS_SIZE-1:0] data);
    case (size)
      2'b00:   store_data = {4{data[7:0]}};
      2'b01:   store_data = {2{data[15:0]}};
      default: store_data = data;
    endcase
  endfunction

  function automatic logic [BITS_SIZE-1:0] load_extend(input logic [1:0] size, input logic [1:0] lane,
                                                       input logic zext, input logic [BITS_SIZE-1:0] word);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (size)
      2'b00:   load_extend = zext ? BITS_SIZE'($unsigned(b)) : BITS_SIZE'(b);
      2'b01:   load_extend = zext ? BITS_SIZE'($unsigned(h)) : BITS_SIZE'(h);
      default: load_extend = word;
    endcase
  endfunction

  assign access = i_step & (i_mem_read | i_mem_write);

`ifdef MEM_MISALIGN_TRAP_EN
  logic mis_p1;

  assign misalign = ((i_datamem_size == 2'b01) && i_alu[0]) ||
                    (i_datamem_size[1] && (i_alu[1:0] != 2'b00));

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) mis_p1 <= 1'b0;
    else          mis_p1 <= (state == IDLE) && access && misalign;
  end

  assign o_misaligned = mis_p1;
`else
  assign misalign     = 1'b0;
  assign o_misaligned = 1'b0;
`endif

  // Counter value after this BUSY cycle reaches the limit: give up on the bus.
  assign timeout_hit = !i_bus_ack && ((wait_cnt + 8'd1) == 8'(TIMEOUT));

  always_comb begin
    state_nxt = state;
    o_stall   = 1'b0;
    case (state)
      IDLE: if (access) begin
        o_stall   = 1'b1;
        state_nxt = misalign ? DONE : BUSY;
      end
      BUSY: begin
        o_stall = 1'b1;
        if (i_bus_ack || timeout_hit) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p0: request captured on BUSY entry, held steady for the whole bus wait.
  always_ff @(posedge i_clk) begin
    if (state == IDLE && access) begin
      addr_p0  <= {i_alu[BITS_SIZE-1:2], 2'b00};
      lane_p0  <= i_alu[1:0];
      size_p0  <= i_datamem_size;
      zext_p0  <= i_zero_extend;
      we_p0    <= i_mem_write;
      be_p0    <= byte_enable(i_datamem_size, i_alu[1:0]);
      wdata_p0 <= store_data(i_datamem_size, i_register_2);
    end
  end

  // Stage p1: completion result and one-cycle DONE pulses.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state        <= IDLE;
      wait_cnt     <= 8'd0;
      load_data_p1 <= '0;
      vld_p1       <= 1'b0;
      err_p1       <= 1'b0;
    end else begin
      state  <= state_nxt;
      vld_p1 <= 1'b0;
      err_p1 <= 1'b0;
      case (state)
        IDLE: begin
          wait_cnt <= 8'd0;
          if (access && misalign) load_data_p1 <= '0;
        end
        BUSY: begin
          if (i_bus_ack) begin
            if (!we_p0) begin
              load_data_p1 <= load_extend(size_p0, lane_p0, zext_p0, i_bus_rdata);
              vld_p1       <= 1'b1;
            end
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
            if (timeout_hit) begin
              err_p1       <= 1'b1;
              load_data_p1 <= '0;
            end
          end
        end
        default: wait_cnt <= 8'd0;
      endcase
    end
  end

  assign o_bus_req    = (state == BUSY);
  assign o_bus_we     = o_bus_req & we_p0;
  assign o_bus_be     = o_bus_req ? be_p0 : 4'b0000;
  assign o_bus_addr   = addr_p0;
  assign o_bus_wdata  = wdata_p0;
  assign o_load_data  = load_data_p1;
  assign o_load_valid = vld_p1;
  assign o_bus_error  = err_p1;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed cases plus randomized accesses against a reference model.
module tb_mem_access_unit;
  localparam int TMO = 16;
`ifdef MEM_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        i_reset, i_step, i_mem_read, i_mem_write, i_zero_extend, i_bus_ack;
  logic [1:0]  i_datamem_size;
  logic [31:0] i_alu, i_register_2, i_bus_rdata;
  logic        o_bus_req, o_bus_we, o_stall, o_load_valid, o_bus_error, o_misaligned;
  logic [31:0] o_bus_addr, o_bus_wdata, o_load_data;
  logic [3:0]  o_bus_be;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.BITS_SIZE(32), .TIMEOUT(TMO)) dut (
    .i_clk(clk), .i_reset(i_reset), .i_step(i_step), .i_mem_read(i_mem_read),
    .i_mem_write(i_mem_write), .i_datamem_size(i_datamem_size), .i_zero_extend(i_zero_extend),
    .i_alu(i_alu), .i_register_2(i_register_2), .o_bus_req(o_bus_req), .o_bus_we(o_bus_we),
    .o_bus_addr(o_bus_addr), .o_bus_be(o_bus_be), .o_bus_wdata(o_bus_wdata),
    .i_bus_ack(i_bus_ack), .i_bus_rdata(i_bus_rdata), .o_stall(o_stall),
    .o_load_data(o_load_data), .o_load_valid(o_load_valid), .o_bus_error(o_bus_error),
    .o_misaligned(o_misaligned)
  );

  // Reference model: plain arithmetic on byte offsets.
  function automatic logic [3:0] m_be(input logic [1:0] size, input logic [31:0] addr);
    int off = int'(addr % 4);
    if (size == 2'd0) return 4'(1 << off);
    if (size == 2'd1) return 4'(3 << (2 * (off / 2)));
    return 4'hF;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [1:0] size, input logic [31:0] d);
    if (size == 2'd0) return (d & 32'hFF) * 32'h01010101;
    if (size == 2'd1) return (d & 32'hFFFF) * 32'h00010001;
    return d;
  endfunction

  function automatic logic [31:0] m_load(input logic [1:0] size, input logic zx,
                                         input logic [31:0] addr, input logic [31:0] w);
    int off = int'(addr % 4);
    logic [31:0] v;
    if (size == 2'd0) begin
      v = (w >> (8 * off)) & 32'hFF;
      if (!zx && v >= 32'd128) v = v + 32'hFFFFFF00;
    end else if (size == 2'd1) begin
      v = (w >> (16 * (off / 2))) & 32'hFFFF;
      if (!zx && v >= 32'd32768) v = v + 32'hFFFF0000;
    end else v = w;
    return v;
  endfunction

  function automatic logic m_mis(input logic [1:0] size, input logic [31:0] addr);
    int off = int'(addr % 4);
    return TRAP && ((size == 2'd1 && (off % 2) == 1) || (size >= 2'd2 && off != 0));
  endfunction

  // Drives one access, answers the bus after ack_lat BUSY cycles (-1 = never), reports what was seen.
  task automatic run_access(
    input logic rd, input logic wr, input logic [1:0] size, input logic zx,
    input logic [31:0] addr, input logic [31:0] data, input logic [31:0] rdata, input int ack_lat,
    output logic req_n, output logic stall_n, output int n_busy,
    output logic [3:0] be, output logic we, output logic [31:0] baddr, output logic [31:0] bwdata,
    output logic stable, output logic stall_done, output logic [31:0] ld,
    output logic lv, output logic err, output logic mis, output logic quiet);
    be = '0; we = 1'b0; baddr = '0; bwdata = '0; stable = 1'b1; n_busy = 0;
    @(posedge clk); #1;
    i_step = 1'b1; i_mem_read = rd; i_mem_write = wr; i_datamem_size = size;
    i_zero_extend = zx; i_alu = addr; i_register_2 = data; i_bus_ack = 1'b0;
    @(negedge clk);
    req_n = o_bus_req; stall_n = o_stall;
    @(posedge clk); #1;
    i_step = 1'b0; i_mem_read = 1'b0; i_mem_write = 1'b0;
    i_datamem_size = 2'($urandom); i_alu = $urandom; i_register_2 = $urandom;
    i_zero_extend = 1'($urandom);
    while (o_bus_req && n_busy < 300) begin
      if (n_busy == 0) begin
        be = o_bus_be; we = o_bus_we; baddr = o_bus_addr; bwdata = o_bus_wdata;
      end else if (o_bus_be !== be || o_bus_we !== we || o_bus_addr !== baddr || o_bus_wdata !== bwdata)
        stable = 1'b0;
      i_bus_ack   = (n_busy == ack_lat);
      i_bus_rdata = (n_busy == ack_lat) ? rdata : $urandom;
      n_busy++;
      @(posedge clk); #1;
      i_bus_ack = 1'b0;
    end
    @(negedge clk);
    stall_done = o_stall; ld = o_load_data; lv = o_load_valid; err = o_bus_error; mis = o_misaligned;
    @(posedge clk); #1;
    quiet = !(o_load_valid | o_bus_error | o_misaligned | o_bus_req);
  endtask

  task automatic test_reset();
    #2;
    checks++; if (o_bus_req !== 1'b0) begin errors++; $display("FAIL rst_req got %b want 0", o_bus_req); end
    checks++; if (o_bus_be !== 4'h0) begin errors++; $display("FAIL rst_be got %h want 0", o_bus_be); end
    checks++; if (o_bus_we !== 1'b0) begin errors++; $display("FAIL rst_we got %b want 0", o_bus_we); end
    checks++; if (o_load_data !== 32'h0) begin errors++; $display("FAIL rst_ld got %h want 0", o_load_data); end
    checks++; if ({o_load_valid, o_bus_error, o_misaligned} !== 3'b000)
      begin errors++; $display("FAIL rst_pulses got %b want 000", {o_load_valid, o_bus_error, o_misaligned}); end
    @(posedge clk); #1;
    i_reset = 1'b1;
  endtask

  task automatic test_load_byte_sign();
    logic rq, sn, we, st, sd, lv, er, ms, qt; logic [3:0] be; logic [31:0] ba, bw, ld; int nb;
    run_access(1'b1, 1'b0, 2'd0, 1'b0, 32'h13, 32'h0, 32'h80AA5511, 0,
               rq, sn, nb, be, we, ba, bw, st, sd, ld, lv, er, ms, qt);
    checks++; if (rq !== 1'b0) begin errors++; $display("FAIL lb_req_N got %b want 0", rq); end
    checks++; if (sn !== 1'b1) begin errors++; $display("FAIL lb_stall_N got %b want 1", sn); end
    checks++; if (nb !== 1) begin errors++; $display("FAIL lb_busy_cycles got %0d want 1", nb); end
    checks++; if (ld !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_data got %h want ffffff80", ld); end
    checks++; if (lv !== 1'b1) begin errors++; $display("FAIL lb_valid got %b want 1", lv); end
    checks++; if (sd !== 1'b0) begin errors++; $display("FAIL lb_stall_done got %b want 0", sd); end
    checks++; if (qt !== 1'b1) begin errors++; $display("FAIL lb_pulse_end got %b want 1", qt); end
  endtask

  task automatic test_store_half();
    logic rq, sn, we, st, sd, lv, er, ms, qt; logic [3:0] be; logic [31:0] ba, bw, ld; int nb;
    run_access(1'b0, 1'b1, 2'd1, 1'b0, 32'h22, 32'h0000BEEF, 32'h0, 0,
               rq, sn, nb, be, we, ba, bw, st, sd, ld, lv, er, ms, qt);
    checks++; if (be !== 4'b1100) begin errors++; $display("FAIL sh_be got %b want 1100", be); end
    checks++; if (bw !== 32'hBEEFBEEF) begin errors++; $display("FAIL sh_wdata got %h want beefbeef", bw); end
    checks++; if (we !== 1'b1) begin errors++; $display("FAIL sh_we got %b want 1", we); end
    checks++; if (ba !== 32'h20) begin errors++; $display("FAIL sh_addr got %h want 20", ba); end
    checks++; if ({sn, nb == 1, sd} !== 3'b110) begin errors++; $display("FAIL sh_stall2 got %b%0d%b want 1 1 0", sn, nb, sd); end
    checks++; if (lv !== 1'b0) begin errors++; $display("FAIL sh_no_valid got %b want 0", lv); end
  endtask

  task automatic test_timeout();
    logic rq, sn, we, st, sd, lv, er, ms, qt; logic [3:0] be; logic [31:0] ba, bw, ld; int nb;
    run_access(1'b1, 1'b0, 2'd2, 1'b0, 32'h40, 32'h0, 32'h12345678, -1,
               rq, sn, nb, be, we, ba, bw, st, sd, ld, lv, er, ms, qt);
    checks++; if (nb !== TMO) begin errors++; $display("FAIL to_busy_cycles got %0d want %0d", nb, TMO); end
    checks++; if (er !== 1'b1) begin errors++; $display("FAIL to_error got %b want 1", er); end
    checks++; if (ld !== 32'h0) begin errors++; $display("FAIL to_data got %h want 0", ld); end
    checks++; if (sd !== 1'b0) begin errors++; $display("FAIL to_stall got %b want 0", sd); end
    checks++; if (qt !== 1'b1) begin errors++; $display("FAIL to_pulse_end got %b want 1", qt); end
    checks++; if (st !== 1'b1) begin errors++; $display("FAIL to_stable got %b want 1", st); end
  endtask

  task automatic test_rw_both();
    logic rq, sn, we, st, sd, lv, er, ms, qt; logic [3:0] be; logic [31:0] ba, bw, ld; int nb;
    run_access(1'b1, 1'b1, 2'd0, 1'b1, 32'h101, 32'h000000A5, 32'hFFFFFFFF, 2,
               rq, sn, nb, be, we, ba, bw, st, sd, ld, lv, er, ms, qt);
    checks++; if (we !== 1'b1) begin errors++; $display("FAIL rw_we got %b want 1", we); end
    checks++; if (be !== 4'b0010) begin errors++; $display("FAIL rw_be got %b want 0010", be); end
    checks++; if (bw !== 32'hA5A5A5A5) begin errors++; $display("FAIL rw_wdata got %h want a5a5a5a5", bw); end
    checks++; if (lv !== 1'b0) begin errors++; $display("FAIL rw_no_valid got %b want 0", lv); end
  endtask

  task automatic test_word_unaligned();
    logic rq, sn, we, st, sd, lv, er, ms, qt; logic [3:0] be; logic [31:0] ba, bw, ld; int nb;
    run_access(1'b1, 1'b0, 2'd2, 1'b0, 32'h05, 32'h0, 32'hCAFEF00D, 0,
               rq, sn, nb, be, we, ba, bw, st, sd, ld, lv, er, ms, qt);
    checks++; if (nb !== (TRAP ? 0 : 1)) begin errors++; $display("FAIL wu_busy got %0d want %0d", nb, TRAP ? 0 : 1); end
    checks++; if (ms !== TRAP) begin errors++; $display("FAIL wu_misaligned got %b want %b", ms, TRAP); end
    checks++; if (be !== (TRAP ? 4'h0 : 4'hF)) begin errors++; $display("FAIL wu_be got %b want %b", be, TRAP ? 4'h0 : 4'hF); end
    checks++; if (ba !== (TRAP ? 32'h0 : 32'h4)) begin errors++; $display("FAIL wu_addr got %h want %h", ba, TRAP ? 32'h0 : 32'h4); end
    checks++; if (ld !== (TRAP ? 32'h0 : 32'hCAFEF00D)) begin errors++; $display("FAIL wu_data got %h want %h", ld, TRAP ? 32'h0 : 32'hCAFEF00D); end
  endtask

  task automatic test_step_low();
    @(posedge clk); #1;
    i_step = 1'b0; i_mem_read = 1'b1; i_datamem_size = 2'd2;
    @(negedge clk);
    checks++; if (o_stall !== 1'b0) begin errors++; $display("FAIL stepoff_stall got %b want 0", o_stall); end
    @(posedge clk); #1;
    checks++; if (o_bus_req !== 1'b0) begin errors++; $display("FAIL stepoff_req got %b want 0", o_bus_req); end
    i_mem_read = 1'b0;
  endtask

  task automatic test_ack_idle();
    @(posedge clk); #1;
    i_bus_ack = 1'b1; i_bus_rdata = 32'h55555555;
    @(posedge clk); #1;
    i_bus_ack = 1'b0;
    checks++; if ({o_load_valid, o_bus_req} !== 2'b00) begin errors++; $display("FAIL idle_ack got %b want 00", {o_load_valid, o_bus_req}); end
  endtask

  task automatic test_random();
    logic rq, sn, we, st, sd, lv, er, ms, qt; logic [3:0] be; logic [31:0] ba, bw, ld; int nb;
    logic rd, wr, zx, mx, ld_op; logic [1:0] sz; logic [31:0] a, d, r; int lat, op;
    for (int i = 0; i < 40; i++) begin
      op = $urandom_range(0, 2);
      rd = (op != 1); wr = (op != 0); ld_op = rd && !wr;
      sz = 2'($urandom); zx = 1'($urandom); a = $urandom; d = $urandom; r = $urandom;
      lat = $urandom_range(0, 5);
      mx = m_mis(sz, a);
      run_access(rd, wr, sz, zx, a, d, r, lat, rq, sn, nb, be, we, ba, bw, st, sd, ld, lv, er, ms, qt);
      checks++; if (nb !== (mx ? 0 : lat + 1)) begin errors++; $display("FAIL rnd%0d_busy got %0d want %0d", i, nb, mx ? 0 : lat + 1); end
      checks++; if (be !== (mx ? 4'h0 : m_be(sz, a))) begin errors++; $display("FAIL rnd%0d_be got %b want %b", i, be, mx ? 4'h0 : m_be(sz, a)); end
      checks++; if (we !== (wr && !mx)) begin errors++; $display("FAIL rnd%0d_we got %b want %b", i, we, wr && !mx); end
      checks++; if (ba !== (mx ? 32'h0 : (a & 32'hFFFFFFFC))) begin errors++; $display("FAIL rnd%0d_addr got %h want %h", i, ba, a & 32'hFFFFFFFC); end
      checks++; if (wr && !mx && bw !== m_wdata(sz, d)) begin errors++; $display("FAIL rnd%0d_wdata got %h want %h", i, bw, m_wdata(sz, d)); end
      checks++; if (st !== 1'b1) begin errors++; $display("FAIL rnd%0d_stable got %b want 1", i, st); end
      checks++; if (lv !== (ld_op && !mx)) begin errors++; $display("FAIL rnd%0d_valid got %b want %b", i, lv, ld_op && !mx); end
      checks++; if (ld_op && ld !== (mx ? 32'h0 : m_load(sz, zx, a, r))) begin errors++; $display("FAIL rnd%0d_data got %h want %h", i, ld, mx ? 32'h0 : m_load(sz, zx, a, r)); end
      checks++; if ({er, ms, sd, qt} !== {1'b0, mx, 1'b0, 1'b1}) begin errors++; $display("FAIL rnd%0d_flags got %b want %b", i, {er, ms, sd, qt}, {1'b0, mx, 1'b0, 1'b1}); end
    end
  endtask

  task automatic test_reset_mid_busy();
    logic rq, sn, we, st, sd, lv, er, ms, qt; logic [3:0] be; logic [31:0] ba, bw, ld; int nb;
    run_access(1'b1, 1'b0, 2'd2, 1'b0, 32'h80, 32'h0, 32'hDEADBEEF, 0,
               rq, sn, nb, be, we, ba, bw, st, sd, ld, lv, er, ms, qt);
    @(posedge clk); #1;
    i_step = 1'b1; i_mem_read = 1'b1; i_datamem_size = 2'd2; i_alu = 32'h84;
    @(posedge clk); #1;
    i_step = 1'b0; i_mem_read = 1'b0;
    @(posedge clk); #3;
    checks++; if (o_bus_req !== 1'b1) begin errors++; $display("FAIL rmb_busy got %b want 1", o_bus_req); end
    i_reset = 1'b0;
    #1;
    checks++; if ({o_bus_req, o_bus_we, o_bus_be} !== 6'h0) begin errors++; $display("FAIL rmb_req_off got %h want 0", {o_bus_req, o_bus_we, o_bus_be}); end
    checks++; if (o_load_data !== 32'h0) begin errors++; $display("FAIL rmb_ld got %h want 0", o_load_data); end
    checks++; if (o_stall !== 1'b0) begin errors++; $display("FAIL rmb_stall got %b want 0", o_stall); end
    @(posedge clk); #1;
    i_reset = 1'b1; i_bus_ack = 1'b1; i_bus_rdata = 32'h11223344;
    @(posedge clk); #1;
    i_bus_ack = 1'b0;
    checks++; if ({o_load_valid, o_bus_req} !== 2'b00) begin errors++; $display("FAIL rmb_late_ack got %b want 00", {o_load_valid, o_bus_req}); end
    @(negedge clk);
    checks++; if (o_load_data !== 32'h0) begin errors++; $display("FAIL rmb_ld_after got %h want 0", o_load_data); end
  endtask

  initial begin
    i_reset = 1'b0; i_step = 1'b0; i_mem_read = 1'b0; i_mem_write = 1'b0; i_zero_extend = 1'b0;
    i_datamem_size = 2'd0; i_alu = '0; i_register_2 = '0; i_bus_ack = 1'b0; i_bus_rdata = '0;
    test_reset();
    test_load_byte_sign();
    test_store_half();
    test_timeout();
    test_rw_both();
    test_word_unaligned();
    test_step_low();
    test_ack_idle();
    test_random();
    test_reset_mid_busy();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameters SHALL be: BITS_SIZE, default 32, data/address width; TIMEOUT, default 16, maximum bus wait cycles (range 2..255).
REQ-002 i_clk  in  1  single clock; all state changes on its rising edge.
REQ-003 i_reset  in  1  asynchronous, active-low reset.
REQ-004 i_step  in  1  pipeline advance enable; no new access starts while low.
REQ-005 i_mem_read / i_mem_write  in  1 each  EX/MEM load / store controls.
REQ-006 i_datamem_size  in  2  access size: 00 byte, 01 half, 10 or 11 word.
REQ-007 i_zero_extend  in  1  1 = zero-extend loads, 0 = sign-extend.
REQ-008 i_alu  in  BITS_SIZE  byte address; i_register_2  in  BITS_SIZE  store data.
REQ-009 o_bus_req, o_bus_we  out  1  bus request and write strobe.
REQ-010 o_bus_addr  out  BITS_SIZE  word-aligned address {i_alu[31:2],2'b00}; o_bus_be  out  4  byte enables; o_bus_wdata  out  BITS_SIZE.
REQ-011 i_bus_ack  in  1  one-cycle completion; i_bus_rdata  in  BITS_SIZE  read word, valid with ack.
REQ-012 o_stall  out  1  pipeline hold; o_load_data  out  BITS_SIZE; o_load_valid, o_bus_error, o_misaligned  out  1 each.

Function
REQ-013 FSM SHALL have states IDLE, BUSY, DONE; access = i_step & (i_mem_read | i_mem_write).
REQ-014 IDLE->BUSY on access; BUSY->DONE on i_bus_ack or timeout; DONE->IDLE unconditionally; otherwise hold.
REQ-015 o_stall SHALL be combinational: 1 in BUSY, 1 in IDLE when access, 0 in DONE, else 0.
REQ-016 o_bus_req SHALL be 1 exactly in BUSY; addr/be/we/wdata stable throughout BUSY.
REQ-017 Read and write both asserted SHALL be a store; the read is ignored.
REQ-018 Store byte enables: byte 0001<<addr[1:0]; half 0011<<(2*addr[1]); word 1111; wdata replicates low byte ×4 / low half ×2 / full word.
REQ-019 Load extraction SHALL be little-endian from the captured ack word: byte lane addr[1:0], half lane addr[1], then extended per i_zero_extend (word unchanged).
REQ-020 o_load_data SHALL be registered at ack; o_load_valid pulses high for the one DONE cycle of a load.
REQ-021 An 8-bit wait counter SHALL clear on BUSY entry and increment each BUSY cycle without ack; reaching TIMEOUT forces DONE with o_bus_error pulsed, o_load_data = 0.
REQ-022 Ack in the first BUSY cycle SHALL give minimum latency: access seen cycle N, req N+1, DONE N+2, stall low N+2.
REQ-023 i_bus_ack outside BUSY SHALL be ignored.

Reset
REQ-024 Reset low SHALL immediately force IDLE, counter 0, o_bus_req/we/be 0, o_load_data 0, all pulse outputs 0, independent of i_clk.
REQ-025 Reset mid-BUSY SHALL abandon the access; a late ack after release is ignored per REQ-023.

Configuration
REQ-026 With MEM_MISALIGN_TRAP_EN defined: half with addr[0]=1 or word with addr[1:0]!=00 SHALL skip BUSY (IDLE->DONE, no o_bus_req) and pulse o_misaligned in DONE; loads return 0.
REQ-027 Without MEM_MISALIGN_TRAP_EN: o_misaligned tied 0; half ignores addr[0], word ignores addr[1:0].

Verification
REQ-028 Load byte addr 0x13, rdata 0x80AA5511, zero_extend 0, ack first BUSY cycle -> o_load_data 0xFFFFFF80, o_load_valid at N+2.
REQ-029 Store half addr 0x22, data 0x0000BEEF -> be 1100, wdata 0xBEEFBEEF, we 1, stall 2 cycles.
REQ-030 No ack for TIMEOUT=16 -> DONE after 16 BUSY cycles, o_bus_error pulse, stall released.
REQ-031 Reset low during BUSY -> o_bus_req 0 same cycle; ack after release -> no o_load_valid.
REQ-032 MEM_MISALIGN_TRAP_EN, load word addr 0x05 -> no o_bus_req, o_misaligned pulse at N+1; undefined -> be 1111, addr 0x04.
